// File: rtl/seg7_scroll_ctrl.sv
// Scroll controller for an eight-digit seven-segment bank: holds up to 16 nibbles and
// scrolls a circular 8-digit window across them; outputs registered nibbles and a blank mask.
module seg7_scroll_ctrl #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [3:0]  wr_data,
  input  logic [4:0]  msg_len,
  input  logic        start,
  input  logic        stop,
  input  logic        step,
  input  logic        dir,
  output logic [31:0] digits,
  output logic [7:0]  blank,
  output logic        busy,
  output logic        wrap,
  output logic [1:0]  state_dbg
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]    state;
  logic [4:0]    len_q;
  logic [3:0]    pos;
  logic [CW-1:0] cnt;
  logic [3:0]    mem [16];

  logic [4:0]    len_in;
  logic          do_adv;
  logic [3:0]    pos_adv;
  logic          adv_wrap;
  logic [4:0]    idx;
  logic [31:0]   win_digits;
  logic [7:0]    win_blank;

  // Handshake note: start/stop/step are level-sampled once per clock; stop outranks start,
  // which outranks step and the scroll tick.
  always_comb len_in = (msg_len > 5'd16) ? 5'd16 : msg_len;

  always_comb begin
    do_adv = 1'b0;
    if (state == S_RUN)       do_adv = !stop && (cnt == TICK_LAST);
    else if (state == S_HOLD) do_adv = !stop && !start && step;
  end

  always_comb begin
    pos_adv  = pos;
    adv_wrap = 1'b0;
    if (!dir) begin
      if ({1'b0, pos} == len_q - 5'd1) begin
        pos_adv  = 4'd0;
        adv_wrap = 1'b1;
      end else begin
        pos_adv = pos + 4'd1;
      end
    end else begin
      if (pos == 4'd0) begin
        pos_adv  = 4'(len_q - 5'd1);
        adv_wrap = 1'b1;
      end else begin
        pos_adv = pos - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      len_q <= 5'd0;
      pos   <= 4'd0;
      cnt   <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (do_adv) begin
        pos  <= pos_adv;
        wrap <= adv_wrap;
      end
      case (state)
        S_IDLE: begin
          if (!stop && start && len_in != 5'd0) begin
            state <= S_RUN;
            len_q <= len_in;
            pos   <= 4'd0;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          if (stop)                   state <= S_HOLD;
          else if (cnt == TICK_LAST)  cnt   <= '0;
          else                        cnt   <= cnt + CW'(1);
        end
        S_HOLD: begin
          if (!stop && start) begin
            state <= S_RUN;
            cnt   <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 4'd0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // pos < len_q and i < len_q keep the sum below 2*len_q, so one subtraction wraps it.
  always_comb begin
    win_digits = 32'd0;
    win_blank  = 8'hFF;
    idx        = 5'd0;
    if (state != S_IDLE) begin
      for (int i = 0; i < 8; i++) begin
        idx = {1'b0, pos} + 5'(i);
        if (idx >= len_q) idx = idx - len_q;
        if (5'(i) < len_q) begin
          win_digits[31-4*i -: 4] = mem[idx[3:0]];
          win_blank[7-i]          = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits <= 32'd0;
      blank  <= 8'hFF;
    end else begin
      digits <= win_digits;
      blank  <= win_blank;
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: doc/seg7_scroll_ctrl.md
# seg7_scroll_ctrl

Scroll controller for the eight DE2-115 seven-segment displays (HEX7..HEX0). It holds a message of up to 16 hex nibbles and advances a circular 8-digit window across it at a programmable rate, with run, hold and single-step control. It outputs eight registered nibbles plus a blank mask. The per-digit hex-to-segment decoders downstream consume these outputs; this block performs no segment encoding.

## Interface
- TICK_DIV, 12_500_000, clk cycles per scroll step (4 Hz at 50 MHz); minimum 2
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write message nibble this cycle
- wr_addr  in  4  message slot 0..15
- wr_data  in  4  nibble value
- msg_len  in  5  message length 0..16; values >16 clamp to 16; sampled only on start from IDLE
- start  in  1  begin scrolling (IDLE) or resume (HOLD), single-cycle pulse
- stop  in  1  freeze scrolling (RUN to HOLD)
- step  in  1  advance one position, honoured in HOLD only
- dir  in  1  0: pos increments, text moves left; 1: pos decrements, text moves right
- digits  out  32  [31:28]=HEX7 (window index 0) .. [3:0]=HEX0 (window index 7)
- blank  out  8  bit 7=HEX7 .. bit 0=HEX0; 1 = digit must be dark
- busy  out  1  state is RUN or HOLD
- wrap  out  1  one-cycle pulse when pos wraps

## Operation
- Storage: mem[0..15] of 4-bit registers, cleared on rst.
  - Writable in any state; a write to slot a sets mem[a] at the sampling edge.
  - Writes never alter len_q or pos.
- Registers: len_q (5 bit), pos (4 bit, 0..len_q-1), tick counter (ceil(log2 TICK_DIV) bits).
- States:
  - IDLE: blank=8'hFF, busy=0.
    - start with clamped msg_len≥1 captures len_q, sets pos=0 and counter=0, goes to RUN.
    - start with msg_len=0 is ignored.
  - RUN: counter increments each cycle.
    - At counter==TICK_DIV-1, pos advances one step and counter returns to 0.
    - stop goes to HOLD with counter held.
  - HOLD: counter frozen.
    - step advances pos once per asserted cycle.
    - start returns to RUN with counter cleared and len_q not resampled.
- Priority per cycle: rst > stop > start > step/tick.
  - start and stop in the same cycle: stop wins (RUN→HOLD, HOLD stays, IDLE stays).
  - step in IDLE or RUN is ignored.
- Advance, dir=0: pos = (pos==len_q-1) ? 0 : pos+1. Wrap pulse when the result is 0 via wrap-around.
- Advance, dir=1: pos = (pos==0) ? len_q-1 : pos-1. Wrap pulse when pos goes 0→len_q-1.
- len_q=1: every advance keeps pos=0 and pulses wrap.
- dir is sampled at each advance and may change freely.
- Window, index i=0..7, when busy:
  - If i<len_q: show mem[(pos+i) mod len_q], blank bit 0.
  - If i≥len_q (possible only for len_q<8): nibble 0, blank bit 1.
- Modulo arithmetic is done in 5 bits; no out-of-range mem index may be formed.

## Timing
- Reset values, visible the cycle after rst is sampled: digits=0, blank=8'hFF, busy=0, wrap=0, state IDLE, pos=0, len_q=0, counter=0, mem all 0.
- rst in any state, including mid-RUN or mid-step, forces the full reset state at the next edge.
- State, pos, busy and wrap update at the edge where the causing input is sampled.
- digits and blank are registered one stage after pos, mem and state: valid at edge E+1 for a change made at edge E.
  - A write to a displayed slot is therefore visible two edges after wr_en is sampled.
- First automatic advance occurs TICK_DIV cycles after start is accepted. Each later advance is spaced exactly TICK_DIV cycles in uninterrupted RUN.
- HOLD→RUN restarts a full TICK_DIV interval.
- wrap is high for exactly one cycle, coincident with the pos update.

## Test plan
- Reset: assert rst 2 cycles → digits=0, blank=8'hFF, busy=0, wrap=0; start with msg_len=0 → busy stays 0.
- Bench TICK_DIV=4.
  - Write mem[k]=k for k=0..15, msg_len=16, start → next edge busy=1, following edge digits=32'h01234567, blank=8'h00.
  - 4 cycles later digits=32'h12345678.
  - After 16 advances: wrap pulses once, digits=32'h01234567.
- dir=1 from pos 0 → pos=15, wrap pulse, digits=32'hF0123456 one cycle later.
- Write mem[0..2]=A,B,C, msg_len=3, start → digits=32'hABC00000, blank=8'h1F; after one tick digits=32'hBCA00000; after 3 ticks wrap has pulsed once.
- Hold:
  - In RUN, stop → busy=1 and no advance over 20 cycles; two step pulses → pos advances by 2.
  - start+stop in the same cycle → remains in HOLD.
  - start → next advance exactly 4 cycles later.
- Write mem[1]=E while RUN at pos 0 → digits[27:24]=E two edges later.
- rst mid-RUN → reset values; mem read back as 0 after restart.
